// File: rtl/bp_be_fflags_rob_pkg.sv
// Shared types for the FP exception-flag reorder buffer: flag bits, rounding
// modes, CSR update ops and the fcsr layout.
package bp_be_fflags_rob_pkg;

   localparam int fflags_width_gp = 5;
   localparam int frm_width_gp    = 3;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_s;

   typedef enum logic [2:0] {
      e_rm_rne = 3'b000,
      e_rm_rtz = 3'b001,
      e_rm_rdn = 3'b010,
      e_rm_rup = 3'b011,
      e_rm_rmm = 3'b100,
      e_rm_dyn = 3'b111
   } rm_e;

   typedef enum logic [1:0] {
      e_csr_write = 2'b00,
      e_csr_set   = 2'b01,
      e_csr_clear = 2'b10,
      e_csr_rsvd  = 2'b11
   } csr_op_e;

   // frm is kept as raw bits so that reserved encodings are stored as written
   typedef struct packed {
      logic [frm_width_gp-1:0] frm;
      fflags_s                 fflags;
   } fcsr_s;

   function automatic logic rm_is_illegal(input logic [frm_width_gp-1:0] rm);
      return rm[2] & (rm[1] | rm[0]);
   endfunction

endpackage

// File: rtl/bp_be_fflags_csr_op.sv
// Combinational CSR write/set/clear applier; the reserved op leaves the value
// untouched.
module bp_be_fflags_csr_op
   import bp_be_fflags_rob_pkg::*;
 #(parameter int width_p = 5)
  (input  logic               en_i,
   input  csr_op_e            op_i,
   input  logic [width_p-1:0] cur_i,
   input  logic [width_p-1:0] operand_i,
   output logic [width_p-1:0] res_o
   );

   always_comb begin
      res_o = cur_i;
      if (en_i) begin
         case (op_i)
            e_csr_write: res_o = operand_i;
            e_csr_set:   res_o = cur_i | operand_i;
            e_csr_clear: res_o = cur_i & ~operand_i;
            default:     res_o = cur_i;
         endcase
      end
   end

endmodule

// File: rtl/bp_be_fflags_rob.sv
// In-order pending buffer of FP exception flags: out-of-order deposit by tag,
// sticky accumulation at commit, plus fcsr.frm storage and rm resolution.
module bp_be_fflags_rob
   import bp_be_fflags_rob_pkg::*;
 #(parameter int num_pipes_p = 2,
   parameter int els_p       = 4,
   parameter bit assert_en_p = 1'b1,
   localparam int tag_width_lp = $clog2(els_p)
   )
  (input  logic                                clk_i,
   input  logic                                reset_n_i,

   input  logic                                alloc_v_i,
   output logic                                alloc_ready_o,
   output logic [tag_width_lp-1:0]             alloc_tag_o,

   input  logic [num_pipes_p-1:0]              done_v_i,
   input  logic [num_pipes_p*tag_width_lp-1:0] done_tag_i,
   input  logic [num_pipes_p*5-1:0]            done_fflags_i,

   input  logic                                commit_v_i,
   output logic                                commit_ready_o,

   input  logic                                flush_i,

   input  logic                                csr_w_v_i,
   input  logic [1:0]                          csr_w_op_i,
   input  logic [4:0]                          csr_w_fflags_i,
   input  logic                                csr_w_frm_v_i,
   input  logic [2:0]                          csr_w_frm_i,

   output logic [4:0]                          fflags_o,
   output logic [2:0]                          frm_o,

   input  logic [2:0]                          instr_rm_i,
   output logic [2:0]                          rm_o,
   output logic                                rm_illegal_o
   );

   localparam int ptr_width_lp = tag_width_lp + 1;

   logic [els_p-1:0]        valid_q, valid_d;
   logic [els_p-1:0]        done_q, done_d;
   logic [els_p-1:0][4:0]   flags_q, flags_d;
   logic [ptr_width_lp-1:0] wptr_q, wptr_d;
   logic [ptr_width_lp-1:0] rptr_q, rptr_d;
   fcsr_s                   fcsr_q, fcsr_d;

   logic [tag_width_lp-1:0] head_idx, tail_idx;
   logic                    full, empty;
   logic                    alloc_fire, commit_fire;
   logic [4:0]              commit_flags;
   logic [4:0]              fflags_pre_csr;
   logic [4:0]              fflags_nxt;
   logic [2:0]              frm_nxt;

   assign head_idx = rptr_q[tag_width_lp-1:0];
   assign tail_idx = wptr_q[tag_width_lp-1:0];

   assign empty = (wptr_q == rptr_q);
   assign full  = (head_idx == tail_idx)
                & (wptr_q[tag_width_lp] != rptr_q[tag_width_lp]);

   assign alloc_ready_o  = ~full;
   assign alloc_tag_o    = tail_idx;
   assign commit_ready_o = valid_q[head_idx] & done_q[head_idx];

   assign alloc_fire  = alloc_v_i & alloc_ready_o & ~flush_i;
   assign commit_fire = commit_v_i & commit_ready_o;

   // Commit reads the registered head, so a same-cycle done on it is lost
   // along with the entry.
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      flags_d = flags_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;

      if (!flush_i) begin
         for (int p = 0; p < num_pipes_p; p++) begin
            if (done_v_i[p]
                && valid_q[done_tag_i[p*tag_width_lp +: tag_width_lp]]) begin
               done_d[done_tag_i[p*tag_width_lp +: tag_width_lp]]  = 1'b1;
               flags_d[done_tag_i[p*tag_width_lp +: tag_width_lp]] =
                  flags_d[done_tag_i[p*tag_width_lp +: tag_width_lp]]
                  | done_fflags_i[p*5 +: 5];
            end
         end
      end

      if (commit_fire) begin
         valid_d[head_idx] = 1'b0;
         done_d[head_idx]  = 1'b0;
         flags_d[head_idx] = '0;
         rptr_d            = rptr_q + ptr_width_lp'(1);
      end

      if (alloc_fire) begin
         valid_d[tail_idx] = 1'b1;
         done_d[tail_idx]  = 1'b0;
         flags_d[tail_idx] = '0;
         wptr_d            = wptr_q + ptr_width_lp'(1);
      end

      if (flush_i) begin
         valid_d = '0;
         done_d  = '0;
         wptr_d  = rptr_d;
      end
   end

   assign commit_flags   = commit_fire ? flags_q[head_idx] : 5'b0;
   assign fflags_pre_csr = fcsr_q.fflags | commit_flags;

   bp_be_fflags_csr_op
    #(.width_p(5))
    fflags_op
     (.en_i      (csr_w_v_i)
      ,.op_i     (csr_op_e'(csr_w_op_i))
      ,.cur_i    (fflags_pre_csr)
      ,.operand_i(csr_w_fflags_i)
      ,.res_o    (fflags_nxt)
      );

   bp_be_fflags_csr_op
    #(.width_p(3))
    frm_op
     (.en_i      (csr_w_v_i & csr_w_frm_v_i)
      ,.op_i     (csr_op_e'(csr_w_op_i))
      ,.cur_i    (fcsr_q.frm)
      ,.operand_i(csr_w_frm_i)
      ,.res_o    (frm_nxt)
      );

   always_comb begin
      fcsr_d        = fcsr_q;
      fcsr_d.fflags = fflags_nxt;
      fcsr_d.frm    = frm_nxt;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q <= '0;
         done_q  <= '0;
         flags_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         fcsr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         flags_q <= flags_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         fcsr_q  <= fcsr_d;
      end
   end

   assign fflags_o = fcsr_q.fflags;
   assign frm_o    = fcsr_q.frm;

   assign rm_o         = (instr_rm_i == e_rm_dyn) ? fcsr_q.frm : instr_rm_i;
   assign rm_illegal_o = rm_is_illegal(rm_o);

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (assert_en_p && reset_n_i) begin
         assert (!(alloc_v_i && full))
            else $error("bp_be_fflags_rob: alloc while full");
         assert (!(commit_v_i && !commit_ready_o))
            else $error("bp_be_fflags_rob: commit without ready head");
         for (int p = 0; p < num_pipes_p; p++) begin
            assert (!(done_v_i[p]
                      && !valid_q[done_tag_i[p*tag_width_lp +: tag_width_lp]]))
               else $error("bp_be_fflags_rob: done to invalid entry, pipe %0d", p);
         end
         assert (!(empty && (valid_q != '0)))
            else $error("bp_be_fflags_rob: valid entry while empty");
      end
   end
`endif

endmodule

// File: tb/tb_bp_be_fflags_rob.sv
// Directed table of per-cycle stimulus with expected post-edge outputs, plus
// hand-written sequences for late done on a committing head and async reset.
module tb_bp_be_fflags_rob;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       alloc_v_i;
   logic       alloc_ready_o;
   logic [1:0] alloc_tag_o;
   logic [1:0] done_v_i;
   logic [3:0] done_tag_i;
   logic [9:0] done_fflags_i;
   logic       commit_v_i;
   logic       commit_ready_o;
   logic       flush_i;
   logic       csr_w_v_i;
   logic [1:0] csr_w_op_i;
   logic [4:0] csr_w_fflags_i;
   logic       csr_w_frm_v_i;
   logic [2:0] csr_w_frm_i;
   logic [4:0] fflags_o;
   logic [2:0] frm_o;
   logic [2:0] instr_rm_i;
   logic [2:0] rm_o;
   logic       rm_illegal_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   bp_be_fflags_rob #(.num_pipes_p(2), .els_p(4), .assert_en_p(1'b0)) dut
     (.clk_i          (clk_i)
      ,.reset_n_i     (reset_n_i)
      ,.alloc_v_i     (alloc_v_i)
      ,.alloc_ready_o (alloc_ready_o)
      ,.alloc_tag_o   (alloc_tag_o)
      ,.done_v_i      (done_v_i)
      ,.done_tag_i    (done_tag_i)
      ,.done_fflags_i (done_fflags_i)
      ,.commit_v_i    (commit_v_i)
      ,.commit_ready_o(commit_ready_o)
      ,.flush_i       (flush_i)
      ,.csr_w_v_i     (csr_w_v_i)
      ,.csr_w_op_i    (csr_w_op_i)
      ,.csr_w_fflags_i(csr_w_fflags_i)
      ,.csr_w_frm_v_i (csr_w_frm_v_i)
      ,.csr_w_frm_i   (csr_w_frm_i)
      ,.fflags_o      (fflags_o)
      ,.frm_o         (frm_o)
      ,.instr_rm_i    (instr_rm_i)
      ,.rm_o          (rm_o)
      ,.rm_illegal_o  (rm_illegal_o)
      );

   typedef struct packed {
      bit       alloc;
      bit [1:0] dv;
      bit [1:0] t0;
      bit [4:0] f0;
      bit [1:0] t1;
      bit [4:0] f1;
      bit       commit;
      bit       flush;
      bit       csr_v;
      bit [1:0] op;
      bit [4:0] cf;
      bit       frm_v;
      bit [2:0] cfrm;
      bit [2:0] irm;
      bit       e_ready;
      bit [1:0] e_tag;
      bit       e_cr;
      bit [4:0] e_ff;
      bit [2:0] e_frm;
      bit [2:0] e_rm;
      bit       e_ill;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input bit alloc, input bit [1:0] dv,
      input bit [1:0] t0, input bit [4:0] f0, input bit [1:0] t1, input bit [4:0] f1,
      input bit commit, input bit flush,
      input bit csr_v, input bit [1:0] op, input bit [4:0] cf,
      input bit frm_v, input bit [2:0] cfrm, input bit [2:0] irm,
      input bit e_ready, input bit [1:0] e_tag, input bit e_cr,
      input bit [4:0] e_ff, input bit [2:0] e_frm, input bit [2:0] e_rm, input bit e_ill);
      vec_t v;
      v.alloc = alloc; v.dv = dv; v.t0 = t0; v.f0 = f0; v.t1 = t1; v.f1 = f1;
      v.commit = commit; v.flush = flush;
      v.csr_v = csr_v; v.op = op; v.cf = cf; v.frm_v = frm_v; v.cfrm = cfrm; v.irm = irm;
      v.e_ready = e_ready; v.e_tag = e_tag; v.e_cr = e_cr;
      v.e_ff = e_ff; v.e_frm = e_frm; v.e_rm = e_rm; v.e_ill = e_ill;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
      end
   endtask

   task automatic idle_inputs();
      alloc_v_i      = 1'b0;
      done_v_i       = '0;
      done_tag_i     = '0;
      done_fflags_i  = '0;
      commit_v_i     = 1'b0;
      flush_i        = 1'b0;
      csr_w_v_i      = 1'b0;
      csr_w_op_i     = '0;
      csr_w_fflags_i = '0;
      csr_w_frm_v_i  = 1'b0;
      csr_w_frm_i    = '0;
   endtask

   task automatic edge_settle();
      @(posedge clk_i);
      #1;
      idle_inputs();
      #1;
   endtask

   task automatic check_state(input string tag, input int row,
                              input bit e_ready, input bit [1:0] e_tag, input bit e_cr,
                              input bit [4:0] e_ff, input bit [2:0] e_frm);
      chk({tag, ".alloc_ready"}, row, 8'(alloc_ready_o), 8'(e_ready));
      chk({tag, ".alloc_tag"},   row, 8'(alloc_tag_o),   8'(e_tag));
      chk({tag, ".commit_ready"},row, 8'(commit_ready_o),8'(e_cr));
      chk({tag, ".fflags"},      row, 8'(fflags_o),      8'(e_ff));
      chk({tag, ".frm"},         row, 8'(frm_o),         8'(e_frm));
   endtask

   initial begin
      // alloc dv t0 f0 t1 f1 cm fl csr op cf frmv cfrm irm | rdy tag cr ff frm rm ill
      // fill to full, fifth alloc dropped
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,1,0, 5'b00000,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,2,0, 5'b00000,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,3,0, 5'b00000,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 5'b00000,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 5'b00000,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,0,0, 5'b00000,0,0,0)); // reset row marker (index 5)
      // out-of-order completion
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,1,0, 5'b00000,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,2,0, 5'b00000,0,0,0));
      vecs.push_back(mk(0,2'b10,0,0,1,5'b00001, 0,0, 0,0,0, 0,0,0, 1,2,0, 5'b00000,0,0,0));
      vecs.push_back(mk(0,2'b01,0,5'b00100,0,0, 0,0, 0,0,0, 0,0,0, 1,2,1, 5'b00000,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,2,1, 5'b00100,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,2,0, 5'b00101,0,0,0));
      // both pipes on the same tag
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,3,0, 5'b00101,0,0,0));
      vecs.push_back(mk(0,2'b11,2,5'b10000,2,5'b00010, 0,0, 0,0,0, 0,0,0, 1,3,1, 5'b00101,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,3,0, 5'b10111,0,0,0));
      // flush with a same-cycle commit and a discarded alloc
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,0,0, 5'b10111,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,1,0, 5'b10111,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 1,0,5'b00000, 0,0,0, 1,2,0, 5'b00000,0,0,0));
      vecs.push_back(mk(0,2'b11,3,5'b10000,0,5'b10000, 0,0, 0,0,0, 0,0,0, 1,2,1, 5'b00000,0,0,0));
      vecs.push_back(mk(0,2'b01,1,5'b10000,0,0, 0,0, 0,0,0, 0,0,0, 1,2,1, 5'b00000,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,2,1, 5'b10000,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 1,1, 0,0,0, 0,0,0, 1,1,0, 5'b10000,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 1,2,0, 5'b10000,0,0,0));
      vecs.push_back(mk(0,2'b10,0,0,1,5'b00001, 0,0, 0,0,0, 0,0,0, 1,2,1, 5'b10000,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,2,0, 5'b10001,0,0,0));
      // CSR op colliding with commit
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 1,0,5'b00001, 0,0,0, 1,3,0, 5'b00001,0,0,0));
      vecs.push_back(mk(0,2'b01,2,5'b01000,0,0, 0,0, 0,0,0, 0,0,0, 1,3,1, 5'b00001,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,0, 1,2,5'b01000, 0,0,0, 1,3,0, 5'b00001,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,0,5'b11111, 0,0,0, 1,3,0, 5'b11111,0,0,0));
      // rounding mode and frm ops
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,0,5'b00000, 1,3'b011,3'b111, 1,3,0, 5'b00000,3'b011,3'b011,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,1,5'b00110, 0,3'b110,3'b111, 1,3,0, 5'b00110,3'b011,3'b011,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,0,5'b00110, 1,3'b101,3'b111, 1,3,0, 5'b00110,3'b101,3'b101,1));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,2,5'b00100, 1,3'b001,3'b111, 1,3,0, 5'b00010,3'b100,3'b100,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 0,0,3'b110, 1,3,0, 5'b00010,3'b100,3'b110,1));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 0,0,0, 0,0,3'b010, 1,3,0, 5'b00010,3'b100,3'b010,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0, 1,3,5'b11111, 1,3'b111,3'b111, 1,3,0, 5'b00010,3'b100,3'b100,0));
      vecs.push_back(mk(1,0,0,0,0,0, 0,0, 0,0,0, 0,0,3'b000, 1,0,0, 5'b00010,3'b100,3'b000,0));

      idle_inputs();
      instr_rm_i = 3'b000;
      reset_n_i  = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      #1;
      check_state("reset", -1, 1, 0, 0, 5'b00000, 3'b000);

      for (int i = 0; i < vecs.size(); i++) begin
         instr_rm_i = vecs[i].irm;
         if (i == 5) begin
            // async reset applied between clock edges
            reset_n_i = 1'b0;
            #1;
            check_state("vec_rst", i, 1, 0, 0, 5'b00000, 3'b000);
            @(posedge clk_i);
            #1 reset_n_i = 1'b1;
            #1;
            continue;
         end
         alloc_v_i      = vecs[i].alloc;
         done_v_i       = vecs[i].dv;
         done_tag_i     = {vecs[i].t1, vecs[i].t0};
         done_fflags_i  = {vecs[i].f1, vecs[i].f0};
         commit_v_i     = vecs[i].commit;
         flush_i        = vecs[i].flush;
         csr_w_v_i      = vecs[i].csr_v;
         csr_w_op_i     = vecs[i].op;
         csr_w_fflags_i = vecs[i].cf;
         csr_w_frm_v_i  = vecs[i].frm_v;
         csr_w_frm_i    = vecs[i].cfrm;
         edge_settle();
         check_state("vec", i, vecs[i].e_ready, vecs[i].e_tag, vecs[i].e_cr,
                     vecs[i].e_ff, vecs[i].e_frm);
         chk("vec.rm_o",       i, 8'(rm_o),         8'(vecs[i].e_rm));
         chk("vec.rm_illegal", i, 8'(rm_illegal_o), 8'(vecs[i].e_ill));
      end

      // done arriving on the head in its commit cycle is dropped with the entry
      done_v_i      = 2'b01;
      done_tag_i    = {2'd0, 2'd3};
      done_fflags_i = {5'b00000, 5'b00001};
      edge_settle();
      chk("late_done.ready_before", 100, 8'(commit_ready_o), 8'd1);
      commit_v_i    = 1'b1;
      done_v_i      = 2'b10;
      done_tag_i    = {2'd3, 2'd0};
      done_fflags_i = {5'b10000, 5'b00000};
      edge_settle();
      chk("late_done.fflags",       101, 8'(fflags_o),       8'b00011);
      chk("late_done.ready_after",  101, 8'(commit_ready_o), 8'd0);

      // async reset mid-stream with non-zero frm and a pending entry
      alloc_v_i      = 1'b1;
      csr_w_v_i      = 1'b1;
      csr_w_op_i     = 2'b00;
      csr_w_fflags_i = 5'b01010;
      csr_w_frm_v_i  = 1'b1;
      csr_w_frm_i    = 3'b110;
      instr_rm_i     = 3'b111;
      edge_settle();
      check_state("pre_rst", 102, 1, 1, 0, 5'b01010, 3'b110);
      chk("pre_rst.rm_illegal", 102, 8'(rm_illegal_o), 8'd1);
      #2 reset_n_i = 1'b0;
      #1;
      check_state("async_rst", 103, 1, 0, 0, 5'b00000, 3'b000);
      chk("async_rst.rm_o", 103, 8'(rm_o), 8'd0);
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      #1;
      alloc_v_i = 1'b1;
      edge_settle();
      check_state("post_rst", 104, 1, 1, 0, 5'b00000, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
